// File: rtl/maq_refri_param.sv
// maq_refri_param: parametrised two-product vending FSM with unit-pulse change; define VENDAS_CNT_EN to add sales counters
module maq_refri_param #(
  parameter int W = 8,
  parameter int V1 = 5,
  parameter int V2 = 10,
  parameter int V3 = 25,
  parameter int PRECO_A = 20,
  parameter int PRECO_B = 35,
  parameter int TROCO_UNID = 5,
  parameter int CRED_MAX = 2**W-1
)(
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   moeda,
  input  logic         sel,
  input  logic         cancela,
  output logic         D1,
  output logic         troco_pulso,
  output logic         moeda_rej,
  output logic [W-1:0] credito,
  output logic         ocupado
`ifdef VENDAS_CNT_EN
  ,
  output logic [15:0]  vendas,
  output logic [15:0]  vendas_b
`endif
);
  typedef enum logic [1:0] {IDLE, ACUMULA, LIBERA, TROCO} state_t;
  localparam logic [W:0]   L_V1  = (W+1)'(V1);
  localparam logic [W:0]   L_V2  = (W+1)'(V2);
  localparam logic [W:0]   L_V3  = (W+1)'(V3);
  localparam logic [W:0]   L_MAX = (W+1)'(CRED_MAX);
  localparam logic [W-1:0] L_PA  = W'(PRECO_A);
  localparam logic [W-1:0] L_PB  = W'(PRECO_B);
  localparam logic [W-1:0] L_U   = W'(TROCO_UNID);
  state_t       r_state, w_nxt;
  logic [W-1:0] r_cred, r_preco, w_cred_nxt, w_preco_nxt, w_price, w_dif;
  logic [1:0]   r_prev;
  logic         r_rej, w_rej_nxt, w_ev;
  logic [W:0]   w_val, w_nv;
  assign w_ev    = moeda != 2'b00 && r_prev == 2'b00;
  assign w_val   = moeda == 2'b01 ? L_V1 : moeda == 2'b10 ? L_V2 : L_V3;
  assign w_nv    = {1'b0, r_cred} + w_val;
  assign w_price = sel ? L_PB : L_PA;
  // LIBERA pays the latched price, TROCO pays one unit per cycle
  assign w_dif   = r_cred - (r_state == LIBERA ? r_preco : L_U);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cred  <= '0;
      r_preco <= '0;
      r_prev  <= 2'b00;
      r_rej   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cred  <= w_cred_nxt;
      r_preco <= w_preco_nxt;
      r_prev  <= moeda;
      r_rej   <= w_rej_nxt;
    end
  end
  always_comb begin
    w_nxt       = r_state;
    w_cred_nxt  = r_cred;
    w_preco_nxt = r_preco;
    w_rej_nxt   = 1'b0;
    if (r_state == LIBERA || r_state == TROCO) begin
      w_rej_nxt  = w_ev;
      w_cred_nxt = w_dif;
      w_nxt      = w_dif == '0 ? IDLE : TROCO;
    end else if (w_ev) begin
      if (w_nv > L_MAX) w_rej_nxt = 1'b1;
      else begin
        w_cred_nxt  = w_nv[W-1:0];
        w_preco_nxt = w_price;
        w_nxt       = w_nv >= {1'b0, w_price} ? LIBERA : ACUMULA;
      end
    end else if (r_state == ACUMULA) begin
      // a switch to a cheaper product can complete the sale without a coin
      if (r_cred >= w_price) begin
        w_preco_nxt = w_price;
        w_nxt       = LIBERA;
      end else if (cancela) w_nxt = TROCO;
    end
  end
  always_comb begin
    D1          = r_state == LIBERA;
    troco_pulso = r_state == TROCO;
    ocupado     = r_state == LIBERA || r_state == TROCO;
    moeda_rej   = r_rej;
    credito     = r_cred;
  end
`ifdef VENDAS_CNT_EN
  logic        r_selb;
  logic [15:0] r_vendas, r_vendas_b;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_selb     <= 1'b0;
      r_vendas   <= '0;
      r_vendas_b <= '0;
    end else begin
      if (w_nxt == LIBERA && r_state != LIBERA) r_selb <= sel;
      if (r_state == LIBERA) r_vendas <= r_vendas + 16'd1;
      if (r_state == LIBERA && r_selb) r_vendas_b <= r_vendas_b + 16'd1;
    end
  end
  assign vendas   = r_vendas;
  assign vendas_b = r_vendas_b;
`endif
endmodule

// File: tb/tb_maq_refri_param.sv
// tb_maq_refri_param: vector table with scoreboard queue plus directed multi-cycle sequences
module tb_maq_refri_param;
  logic       clk = 1'b0;
  logic       rst = 1'b0, sel = 1'b0, cancela = 1'b0;
  logic [1:0] moeda = 2'b00, m2 = 2'b00;
  logic       d1, tp, rej, ocup, d1_2, tp_2, rej_2, ocup_2;
  logic [7:0] cred;
  logic [4:0] cred2;
`ifdef VENDAS_CNT_EN
  logic [15:0] vendas, vendas_b, vendas2, vendas2_b;
  int ev = 0, evb = 0;
`endif
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  maq_refri_param dut (
    .clk(clk), .rst(rst), .moeda(moeda), .sel(sel), .cancela(cancela),
    .D1(d1), .troco_pulso(tp), .moeda_rej(rej), .credito(cred), .ocupado(ocup)
`ifdef VENDAS_CNT_EN
    , .vendas(vendas), .vendas_b(vendas_b)
`endif
  );
  maq_refri_param #(.W(5), .PRECO_A(30), .PRECO_B(30)) dut2 (
    .clk(clk), .rst(rst), .moeda(m2), .sel(1'b0), .cancela(1'b0),
    .D1(d1_2), .troco_pulso(tp_2), .moeda_rej(rej_2), .credito(cred2), .ocupado(ocup_2)
`ifdef VENDAS_CNT_EN
    , .vendas(vendas2), .vendas_b(vendas2_b)
`endif
  );
  typedef struct {
    logic       r;
    logic [1:0] m;
    logic       s, c, d1, tp, rej;
    logic [7:0] cred;
    logic       ocup;
  } vec_t;
  vec_t tab[$];
  vec_t sb[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic add(input int r, m, s, c, e_d1, e_tp, e_rej, e_cred, e_ocup);
    tab.push_back('{r[0], m[1:0], s[0], c[0], e_d1[0], e_tp[0], e_rej[0], e_cred[7:0], e_ocup[0]});
  endtask
  initial begin
    vec_t e;
    int np;
    //  rst m  s  c  d1 tp rej cred ocup
    add(1, 0, 0, 0, 0, 0, 0, 0,  0);
    add(0, 1, 0, 0, 0, 0, 0, 5,  0);
    add(0, 0, 0, 0, 0, 0, 0, 5,  0);
    add(0, 2, 0, 0, 0, 0, 0, 15, 0);
    add(0, 0, 0, 0, 0, 0, 0, 15, 0);
    add(0, 2, 0, 0, 1, 0, 0, 25, 1);
    add(0, 0, 0, 0, 0, 1, 0, 5,  1);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0);
    add(0, 3, 0, 0, 1, 0, 0, 25, 1);
    add(0, 0, 0, 0, 0, 1, 0, 5,  1);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0);
    add(0, 2, 0, 0, 0, 0, 0, 10, 0);
    add(0, 0, 0, 0, 0, 0, 0, 10, 0);
    add(0, 2, 0, 0, 1, 0, 0, 20, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0);
    add(0, 2, 1, 0, 0, 0, 0, 10, 0);
    add(0, 0, 1, 0, 0, 0, 0, 10, 0);
    add(0, 2, 1, 0, 0, 0, 0, 20, 0);
    add(0, 0, 1, 0, 0, 0, 0, 20, 0);
    add(0, 2, 1, 0, 0, 0, 0, 30, 0);
    add(0, 0, 1, 0, 0, 0, 0, 30, 0);
    add(0, 2, 1, 0, 1, 0, 0, 40, 1);
    add(0, 0, 1, 0, 0, 1, 0, 5,  1);
    add(0, 0, 1, 0, 0, 0, 0, 0,  0);
    add(0, 0, 0, 1, 0, 0, 0, 0,  0);
    add(0, 2, 0, 0, 0, 0, 0, 10, 0);
    add(0, 0, 0, 1, 0, 1, 0, 10, 1);
    add(0, 0, 0, 1, 0, 1, 0, 5,  1);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0);
    add(0, 3, 1, 0, 0, 0, 0, 25, 0);
    add(0, 3, 1, 0, 0, 0, 0, 25, 0);
    add(0, 3, 1, 0, 0, 0, 0, 25, 0);
    add(0, 3, 1, 0, 0, 0, 0, 25, 0);
    add(0, 0, 1, 0, 0, 0, 0, 25, 0);
    add(0, 0, 1, 1, 0, 1, 0, 25, 1);
    add(0, 0, 1, 0, 0, 1, 0, 20, 1);
    add(0, 3, 1, 0, 0, 1, 1, 15, 1);
    add(0, 3, 1, 0, 0, 1, 0, 10, 1);
    add(0, 0, 1, 0, 0, 1, 0, 5,  1);
    add(0, 0, 1, 0, 0, 0, 0, 0,  0);
    add(0, 3, 1, 0, 0, 0, 0, 25, 0);
    add(0, 0, 0, 0, 1, 0, 0, 25, 1);
    add(0, 1, 0, 0, 0, 1, 1, 5,  1);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0);
    add(0, 2, 0, 1, 0, 0, 0, 10, 0);
    add(0, 0, 0, 1, 0, 1, 0, 10, 1);
    add(0, 0, 0, 0, 0, 1, 0, 5,  1);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0);
    add(0, 2, 0, 0, 0, 0, 0, 10, 0);
    add(0, 0, 0, 1, 0, 1, 0, 10, 1);
    add(0, 0, 0, 0, 0, 1, 0, 5,  1);
    add(1, 0, 0, 0, 0, 0, 0, 0,  0);
    add(0, 0, 0, 0, 0, 0, 0, 0,  0);
    foreach (tab[i]) begin
      rst = tab[i].r; moeda = tab[i].m; sel = tab[i].s; cancela = tab[i].c;
      sb.push_back(tab[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("row%0d D1", i), d1, e.d1);
      chk($sformatf("row%0d troco_pulso", i), tp, e.tp);
      chk($sformatf("row%0d moeda_rej", i), rej, e.rej);
      chk($sformatf("row%0d credito", i), cred, e.cred);
      chk($sformatf("row%0d ocupado", i), ocup, e.ocup);
`ifdef VENDAS_CNT_EN
      if (tab[i].r) begin ev = 0; evb = 0; end
      else if (i > 0 && tab[i-1].d1) begin ev++; if (tab[i-1].s) evb++; end
      chk($sformatf("row%0d vendas", i), vendas, ev);
      chk($sformatf("row%0d vendas_b", i), vendas_b, evb);
`endif
    end
    rst = 1'b0; cancela = 1'b0; sel = 1'b1;
    moeda = 2'b11; @(posedge clk); #1;
    moeda = 2'b00; @(posedge clk); #1;
    moeda = 2'b11; @(posedge clk); #1;
    chk("seq50 D1 latency", d1, 1);
    chk("seq50 credito", cred, 50);
    moeda = 2'b00;
    np = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (tp) np++;
      if (!ocup) break;
    end
    chk("seq50 troco pulses", np, 3);
    chk("seq50 idle in time", ocup, 0);
    chk("seq50 credito end", cred, 0);
    m2 = 2'b11; @(posedge clk); #1;
    chk("w5 credito 25", cred2, 25);
    m2 = 2'b00; @(posedge clk); #1;
    m2 = 2'b10; @(posedge clk); #1;
    chk("w5 reject pulse", rej_2, 1);
    chk("w5 credito kept", cred2, 25);
    chk("w5 no D1", d1_2, 0);
    m2 = 2'b00; @(posedge clk); #1;
    chk("w5 reject one cycle", rej_2, 0);
    chk("w5 credito still", cred2, 25);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
